// File: rtl/mac_sequencer_if.sv
// Chunk stream and macgen connection for the MAC sequencer.
// The master side is the sequencer; the slave side is the message source plus macgen.
interface mac_sequencer_if #(
    parameter int CHUNK_W = 256
);
    logic               in_valid;
    logic [CHUNK_W-1:0] in_data;
    logic               in_ready;
    logic [CHUNK_W-1:0] mg_key;
    logic [CHUNK_W-1:0] mg_data;
    logic               mg_enable;
    logic [CHUNK_W-1:0] mg_mac;

    modport master (
        input  in_valid, in_data, mg_mac,
        output in_ready, mg_key, mg_data, mg_enable
    );

    modport slave (
        output in_valid, in_data, mg_mac,
        input  in_ready, mg_key, mg_data, mg_enable
    );
endinterface

// File: rtl/mac_sequencer.sv
// Sequences an external combinational macgen over a chained multi-chunk message
// and emits the final tag, optionally compared against an expected tag.
module mac_sequencer #(
    parameter int CHUNK_W = 256,
    parameter int LEN_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [CHUNK_W-1:0] key_i,
    input  logic [LEN_W-1:0]   num_chunks_i,
    input  logic               verify_i,
    input  logic [CHUNK_W-1:0] exp_tag_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic [CHUNK_W-1:0] tag_o,
    output logic               tag_valid_o,
    output logic               tag_match_o,
    output logic               err_o,
    mac_sequencer_if.master    bus
);

    typedef enum logic [1:0] {IDLE, RUN, PROC, DONE} state_t;

    state_t             state_q, state_d;
    logic [CHUNK_W-1:0] acc_q, acc_d;
    logic [CHUNK_W-1:0] data_q, data_d;
    logic [CHUNK_W-1:0] key_q, key_d;
    logic [CHUNK_W-1:0] exp_q, exp_d;
    logic [CHUNK_W-1:0] tag_q, tag_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   num_q, num_d;
    logic               verify_q, verify_d;
    logic               match_q, match_d;
    logic               tag_valid_q, tag_valid_d;
    logic               err_q, err_d;

    logic               in_ready;
    logic               mg_enable;
    logic [CHUNK_W-1:0] mg_key;
    logic [CHUNK_W-1:0] mg_data;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        data_d      = data_q;
        key_d       = key_q;
        exp_d       = exp_q;
        tag_d       = tag_q;
        cnt_d       = cnt_q;
        num_d       = num_q;
        verify_d    = verify_q;
        match_d     = match_q;
        tag_valid_d = 1'b0;
        err_d       = 1'b0;
        in_ready    = 1'b0;
        mg_enable   = 1'b0;
        mg_key      = '0;
        mg_data     = '0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (num_chunks_i == '0) begin
                        err_d = 1'b1;
                    end else begin
                        key_d    = key_i;
                        num_d    = num_chunks_i;
                        verify_d = verify_i;
                        exp_d    = exp_tag_i;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                // Abort wins over a same-cycle chunk, so the chunk is never acknowledged.
                in_ready = !abort_i;
                if (abort_i) begin
                    acc_d   = '0;
                    state_d = IDLE;
                end else if (bus.in_valid) begin
                    data_d  = bus.in_data ^ acc_q;
                    state_d = PROC;
                end
            end
            PROC: begin
                mg_enable = 1'b1;
                mg_key    = key_q;
                mg_data   = data_q;
                if (abort_i) begin
                    acc_d   = '0;
                    state_d = IDLE;
                end else begin
                    acc_d   = bus.mg_mac;
                    cnt_d   = cnt_q + LEN_W'(1);
                    state_d = (cnt_q == num_q - LEN_W'(1)) ? DONE : RUN;
                end
            end
            DONE: begin
                if (abort_i) begin
                    acc_d = '0;
                end else begin
                    tag_d       = acc_q;
                    match_d     = verify_q & (acc_q == exp_q);
                    tag_valid_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            data_q      <= '0;
            key_q       <= '0;
            exp_q       <= '0;
            tag_q       <= '0;
            cnt_q       <= '0;
            num_q       <= '0;
            verify_q    <= 1'b0;
            match_q     <= 1'b0;
            tag_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            data_q      <= data_d;
            key_q       <= key_d;
            exp_q       <= exp_d;
            tag_q       <= tag_d;
            cnt_q       <= cnt_d;
            num_q       <= num_d;
            verify_q    <= verify_d;
            match_q     <= match_d;
            tag_valid_q <= tag_valid_d;
            err_q       <= err_d;
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign tag_o         = tag_q;
    assign tag_valid_o   = tag_valid_q;
    assign tag_match_o   = match_q;
    assign err_o         = err_q;
    assign bus.in_ready  = in_ready;
    assign bus.mg_enable = mg_enable;
    assign bus.mg_key    = mg_key;
    assign bus.mg_data   = mg_data;

endmodule

// File: tb/tb_mac_sequencer.sv
// Randomised scoreboard bench for mac_sequencer with a behavioural macgen and tag model.
module tb_mac_sequencer;
    localparam int CW = 256;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] key = '0;
    logic [LW-1:0] num = '0;
    logic          verify = 1'b0;
    logic [CW-1:0] exp_tag = '0;
    logic          abort = 1'b0;
    logic          busy;
    logic [CW-1:0] tag;
    logic          tag_valid;
    logic          tag_match;
    logic          err;

    mac_sequencer_if #(.CHUNK_W(CW)) bus ();

    mac_sequencer #(.CHUNK_W(CW), .LEN_W(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .key_i        (key),
        .num_chunks_i (num),
        .verify_i     (verify),
        .exp_tag_i    (exp_tag),
        .abort_i      (abort),
        .busy_o       (busy),
        .tag_o        (tag),
        .tag_valid_o  (tag_valid),
        .tag_match_o  (tag_match),
        .err_o        (err),
        .bus          (bus)
    );

    // Behavioural macgen: MAC = key XOR data.
    assign bus.mg_mac = bus.mg_key ^ bus.mg_data;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [CW-1:0] tag;
        bit            match;
        int            lat;
        int            c0;
    } exp_t;

    exp_t          sbq[$];
    logic [CW-1:0] chunks[$];
    logic [CW-1:0] last_tag = '0;
    bit            last_match = 1'b0;
    int checks = 0, failures = 0;
    int err_exp = 0, err_seen = 0, mg_exp = 0, mg_seen = 0;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, expv);
        end
    endtask

    function automatic logic [CW-1:0] rand256();
        logic [CW-1:0] v;
        for (int i = 0; i < CW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (err) err_seen++;
            if (bus.mg_enable) mg_seen++;
            if (tag_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_tag_valid", CW'(tag_valid), '0);
                end else begin
                    e = sbq.pop_front();
                    check("tag", tag, e.tag);
                    check("tag_match", CW'(tag_match), CW'(e.match));
                    if (e.lat >= 0) check("tag_latency", CW'(cyc - e.c0), CW'(e.lat));
                end
            end
        end
    end

    // Message of chunks[] (already filled); gap cycles before each chunk, abort in PROC of chunk abort_at.
    task automatic run_msg(input logic [CW-1:0] k, input bit ver, input bit flip,
                           input int fixgap, input int randgap, input int abort_at, input bit ign_start);
        int n, c0, gap;
        bit held, ok;
        logic [CW-1:0] expected;
        n = chunks.size();
        held = (fixgap == 0) && (randgap == 0);
        // Key cancels in pairs under XOR chaining, so the tag is the XOR of all chunks plus key if N is odd.
        expected = (n % 2 == 1) ? k : '0;
        foreach (chunks[i]) expected ^= chunks[i];
        key = k; num = LW'(n); verify = ver;
        exp_tag = flip ? (expected ^ CW'(1)) : expected;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; c0 = cyc;
        key = rand256(); exp_tag = rand256(); num = LW'($urandom); verify = $urandom_range(0, 1);
        if (abort_at < 0) begin
            sbq.push_back('{tag: expected, match: ver & !flip, lat: held ? 2*n+1 : -1, c0: c0});
            last_tag = expected; last_match = ver & !flip;
        end
        for (int i = 0; i < n; i++) begin
            gap = fixgap + ((randgap > 0) ? $urandom_range(0, randgap) : 0);
            repeat (gap) begin @(posedge clk); #1; end
            bus.in_valid = 1'b1; bus.in_data = chunks[i];
            if (ign_start && i == 0) begin
                start = 1'b1; num = LW'($urandom_range(1, 9)); key = rand256();
            end
            ok = 1'b0;
            for (int t = 0; t < 50 && !ok; t++) begin
                @(negedge clk);
                if (bus.in_ready) begin @(posedge clk); #1; ok = 1'b1; end
            end
            start = 1'b0;
            if (!ok) begin
                check("accept_timeout", '0, CW'(1));
                bus.in_valid = 1'b0;
                return;
            end
            mg_exp++;
            if (!held) bus.in_valid = 1'b0;
            if (abort_at == i) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0; bus.in_valid = 1'b0;
                check("abort_busy", CW'(busy), '0);
                @(negedge clk);
                check("abort_tag_hold", tag, last_tag);
                return;
            end
            @(negedge clk);
            check("proc_in_ready", CW'(bus.in_ready), '0);
            check("proc_mg_key", bus.mg_key, k);
        end
        bus.in_valid = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (!busy) ok = 1'b1; else begin @(posedge clk); #1; end
        end
        if (!ok) check("done_timeout", CW'(busy), '0);
        @(negedge clk);
    endtask

    task automatic zero_start();
        num = '0; key = rand256(); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; err_exp++;
        check("err_busy", CW'(busy), '0);
        @(negedge clk);
        check("err_pulse", CW'(err), CW'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("err_cleared", CW'(err), '0);
        check("err_tag_hold", tag, last_tag);
    endtask

    initial begin
        logic [CW-1:0] k, d;
        int n, ab;
        bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", CW'(busy), '0);
        check("rst_in_ready", CW'(bus.in_ready), '0);
        check("rst_tag", tag, '0);
        check("rst_tag_match", CW'(tag_match), '0);
        check("rst_mg_enable", CW'(bus.mg_enable), '0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Single chunk, in_valid held
        k = {32{8'hAA}};
        d = {4{64'h0123_4567_89AB_CDEF}};
        chunks = {d};
        run_msg(k, 1'b0, 1'b0, 0, 0, -1, 1'b0);

        // Asynchronous reset mid-RUN
        key = rand256(); num = 8'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_busy", CW'(busy), '0);
        check("arst_in_ready", CW'(bus.in_ready), '0);
        check("arst_tag", tag, '0);
        check("arst_mg_enable", CW'(bus.mg_enable), '0);
        check("arst_tag_valid", CW'(tag_valid), '0);
        last_tag = '0; last_match = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Two chunks continuous: key cancels
        chunks = {CW'(1), CW'(2)};
        run_msg(rand256(), 1'b0, 1'b0, 0, 0, -1, 1'b0);
        check("two_chunk_tag", tag, CW'(3));

        // Backpressure with verify, then mismatched expected tag
        chunks = {rand256(), rand256(), rand256()};
        run_msg(rand256(), 1'b1, 1'b0, 4, 0, -1, 1'b0);
        run_msg(rand256(), 1'b1, 1'b1, 4, 0, -1, 1'b0);

        zero_start();

        // Abort in PROC of chunk 2 of 3, stray start while busy, then a clean message
        chunks = {rand256(), rand256(), rand256()};
        run_msg(rand256(), 1'b1, 1'b0, 0, 0, 1, 1'b0);
        chunks = {rand256(), rand256()};
        run_msg(rand256(), 1'b1, 1'b0, 0, 2, -1, 1'b1);
        chunks = {rand256()};
        run_msg(rand256(), 1'b0, 1'b0, 0, 0, -1, 1'b0);

        // Abort in RUN with a chunk offered in the same cycle
        key = rand256(); num = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = rand256(); abort = 1'b1;
        @(negedge clk);
        check("abort_run_in_ready", CW'(bus.in_ready), '0);
        @(posedge clk); #1;
        abort = 1'b0; bus.in_valid = 1'b0;
        check("abort_run_busy", CW'(busy), '0);
        @(negedge clk);
        check("abort_run_mg_enable", CW'(bus.mg_enable), '0);

        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 9) == 0) begin
                zero_start();
            end else begin
                n = $urandom_range(1, 6);
                chunks = {};
                for (int i = 0; i < n; i++) chunks.push_back(rand256());
                ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
                run_msg(rand256(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        0, ($urandom_range(0, 1) == 1) ? 3 : 0, ab, 1'($urandom_range(0, 3) == 0));
            end
        end

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", CW'(sbq.size()), '0);
        check("err_pulse_count", CW'(err_seen), CW'(err_exp));
        check("mg_enable_cycles", CW'(mg_seen), CW'(mg_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Controller that sequences the combinational MAC generator (macgen) over a multi-chunk message of 256-bit chunks.
- Sits between the message source (valid/ready stream) and the macgen instance, which is external and connected via the mg_* ports.
- Chains chunks so each result depends on all previous chunks, then emits the final 256-bit tag.
- Optionally compares the tag against an expected tag for the decrypt/verify path.

Parameters:
- CHUNK_W, 256: chunk, key and tag width; must match macgen.
- LEN_W, 8: width of the chunk-count field; a message has at most 2^LEN_W-1 chunks.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a message; sampled only in IDLE.
- key  input  CHUNK_W  MAC key; latched on an accepted start.
- num_chunks  input  LEN_W  chunks in the message; latched on start.
- verify  input  1  enable tag comparison; latched on start.
- exp_tag  input  CHUNK_W  expected tag; latched on start.
- abort  input  1  cancel the current message.
- busy  output  1  high in every state except IDLE.
- in_valid  input  1  chunk valid.
- in_data  input  CHUNK_W  chunk data.
- in_ready  output  1  chunk accept; high only in RUN.
- mg_key  output  CHUNK_W  to macgen key.
- mg_data  output  CHUNK_W  to macgen data.
- mg_enable  output  1  to macgen enable.
- mg_mac  input  CHUNK_W  from macgen MAC.
- tag  output  CHUNK_W  final tag; registered.
- tag_valid  output  1  one-cycle pulse when tag is updated.
- tag_match  output  1  verify result; registered.
- err  output  1  one-cycle pulse on start with num_chunks==0.

Behaviour:
- Reset values: state=IDLE; acc, data_reg, key_reg, tag = 0; cnt=0; busy, in_ready, mg_enable, tag_valid, tag_match, err = 0.
- mg_key, mg_data and mg_enable are 0 in every state except PROC.
- IDLE:
  - start with num_chunks!=0: latch key, num_chunks, verify and exp_tag; acc<=0; cnt<=0; go to RUN.
  - start with num_chunks==0: err=1 for one cycle; stay in IDLE.
  - start while busy is ignored.
- RUN: in_ready=1. On in_valid&in_ready: data_reg<=in_data^acc; go to PROC. in_valid low means wait indefinitely.
- PROC:
  - mg_enable=1, mg_key=key_reg, mg_data=data_reg.
  - On the clock edge: acc<=mg_mac; cnt<=cnt+1.
  - If cnt==num_chunks-1, go to DONE; else go to RUN.
- DONE:
  - tag<=acc; tag_match<=verify&(acc==exp_tag); tag_valid=1 for exactly one cycle; go to IDLE.
  - tag and tag_match hold until the next DONE or reset.
- Chaining rule: acc_n = key ^ (chunk_n ^ acc_{n-1}), with acc_0 = 0 (XOR only, no carries).
- Throughput: one chunk per 2 cycles. With in_valid held high, tag_valid asserts 2N+1 cycles after the start edge.
- abort:
  - In RUN, PROC or DONE: go to IDLE next edge. No tag_valid; tag and tag_match are unchanged; acc is cleared.
  - abort has priority over a same-cycle chunk accept. A chunk on in_data in that cycle is not consumed (in_ready is forced low).
  - abort in IDLE: no effect.
- cnt is LEN_W bits wide and cannot wrap, because num_chunks is at most 2^LEN_W-1.
- rst mid-message: immediate return to reset values; the next message starts clean.

Test Plan:
- Reset then idle: assert rst mid-RUN -> busy=0, in_ready=0, tag=0 and mg_enable=0 asynchronously; no tag_valid.
- Single chunk: K=256'hAA..AA, N=1, D1=256'h0123..EF, in_valid held -> tag=K^D1; tag_valid 3 cycles after start; mg_enable high exactly 1 cycle.
- Two chunks, continuous: N=2, D1=256'h1, D2=256'h2 -> tag=D1^D2=256'h3 (key cancels); tag_valid at cycle 5; in_ready pattern 1,0,1,0.
- Backpressure and verify: N=3, in_valid gaps of 4 cycles, verify=1, exp_tag=K^D1^D2^D3 -> tag_match=1; repeat with exp_tag bit 0 flipped -> tag_match=0.
- num_chunks=0: start -> err pulse 1 cycle, busy stays 0, tag unchanged.
- Abort and ignored start: abort during PROC of chunk 2 of 3 -> IDLE, no tag_valid. Then start (issued while busy in a separate run) is ignored; a fresh start with N=1 gives tag=K^D1 (acc cleared).
